// File: rtl/ysyx_25020047_mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_25020047_mem_arb_pkg
// Purpose  : Shared types and constants for the IFU/LSU memory arbiter:
//            FSM state encoding, owner encoding, grant bit positions and
//            default bus widths.
// Revision : 1.0 - initial release
// ============================================================================
package ysyx_25020047_mem_arb_pkg;

    // Default address/data widths of every arbiter port
    localparam int c_DEFAULT_AW = 32;
    localparam int c_DEFAULT_DW = 32;

    // Bit positions inside the one-hot grant vector
    localparam int c_GNT_IFU = 0;
    localparam int c_GNT_LSU = 1;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    // Owner of the single outstanding transaction
    typedef enum logic {
        OWNER_IFU = 1'b0,
        OWNER_LSU = 1'b1
    } owner_t;

endpackage
`default_nettype wire

// File: rtl/ysyx_25020047_arb_sel.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_25020047_arb_sel
// Purpose  : Grant selection between IFU and LSU requesters. Produces a
//            one-hot grant (bit0 = IFU, bit1 = LSU).
//            YSYX_25020047_ARB_RR_EN defined : ties resolved round-robin
//                                              from i_last_grant.
//            YSYX_25020047_ARB_RR_EN absent  : ties go to the LSU.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_25020047_arb_sel
    import ysyx_25020047_mem_arb_pkg::*;
(
    input  logic       i_ifu_valid,
    input  logic       i_lsu_valid,
    input  logic       i_last_grant,
    output logic [1:0] o_grant
);

    // Pick at most one requester; only a tie depends on the configuration
    always_comb begin
        o_grant = 2'b00;
        if (i_ifu_valid && i_lsu_valid) begin
`ifdef YSYX_25020047_ARB_RR_EN
            // Whoever was not served last time wins the tie
            if (i_last_grant == OWNER_LSU) begin
                o_grant[c_GNT_IFU] = 1'b1;
            end else begin
                o_grant[c_GNT_LSU] = 1'b1;
            end
`else
            // Data accesses stall the pipeline harder than fetches
            o_grant[c_GNT_LSU] = 1'b1;
`endif
        end else if (i_lsu_valid) begin
            o_grant[c_GNT_LSU] = 1'b1;
        end else if (i_ifu_valid) begin
            o_grant[c_GNT_IFU] = 1'b1;
        end
    end

`ifndef YSYX_25020047_ARB_RR_EN
    // Fixed priority has no history; the input is kept for a uniform port list
    logic w_unused_last_grant;
    assign w_unused_last_grant = i_last_grant;
`endif

endmodule
`default_nettype wire

// File: rtl/ysyx_25020047_mem_arb.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_25020047_mem_arb
// Purpose  : Single-outstanding memory arbiter between the instruction
//            fetch unit (IFU) and the load/store unit (LSU). A grant in
//            IDLE latches the request, ISSUE presents it to memory until
//            accepted, WAIT routes the response back to the owner.
//            Optional macro YSYX_25020047_ARB_RR_EN selects round-robin
//            tie-breaking instead of LSU-first fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_25020047_mem_arb
    import ysyx_25020047_mem_arb_pkg::*;
#(
    parameter int AW = c_DEFAULT_AW,
    parameter int DW = c_DEFAULT_DW
) (
    input  logic            clock,
    input  logic            reset,

    // IFU request / response
    input  logic            ifu_req_valid,
    output logic            ifu_req_ready,
    input  logic [AW-1:0]   ifu_addr,
    output logic            ifu_rsp_valid,
    output logic [DW-1:0]   ifu_rsp_data,

    // LSU request / response
    input  logic            lsu_req_valid,
    output logic            lsu_req_ready,
    input  logic [AW-1:0]   lsu_addr,
    input  logic            lsu_wen,
    input  logic [DW-1:0]   lsu_wdata,
    input  logic [DW/8-1:0] lsu_wmask,
    output logic            lsu_rsp_valid,
    output logic [DW-1:0]   lsu_rsp_data,

    // Memory request / response
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [AW-1:0]   mem_addr,
    output logic            mem_wen,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_wmask,
    input  logic            mem_rsp_valid,
    input  logic [DW-1:0]   mem_rsp_data
);

    localparam int c_MW = DW / 8;

    arb_state_t      r_state;
    arb_state_t      w_state_nxt;
    owner_t          r_owner;
    logic [AW-1:0]   r_addr;
    logic            r_wen;
    logic [DW-1:0]   r_wdata;
    logic [c_MW-1:0] r_wmask;
    logic            r_post_rst;

    logic            w_quiet;
    logic [1:0]      w_sel_grant;
    logic            w_last_grant;
    logic            w_grant_ifu;
    logic            w_grant_lsu;
    logic            w_issue;
    logic            w_rsp_fire;
    logic            w_ifu_fire;
    logic            w_lsu_fire;

    // Outputs are silenced during reset and for one cycle afterwards
    assign w_quiet = reset | r_post_rst;

`ifdef YSYX_25020047_ARB_RR_EN
    owner_t r_last_grant;

    // Remember who won the latest grant so that ties alternate
    always_ff @(posedge clock) begin
        if (reset) begin
            r_last_grant <= OWNER_IFU;
        end else if (w_grant_lsu) begin
            r_last_grant <= OWNER_LSU;
        end else if (w_grant_ifu) begin
            r_last_grant <= OWNER_IFU;
        end
    end

    assign w_last_grant = r_last_grant;
`else
    assign w_last_grant = 1'b0;
`endif

    ysyx_25020047_arb_sel u_arb_sel (
        .i_ifu_valid  (ifu_req_valid),
        .i_lsu_valid  (lsu_req_valid),
        .i_last_grant (w_last_grant),
        .o_grant      (w_sel_grant)
    );

    // Flag the first cycle after reset so no grant or output leaks out
    always_ff @(posedge clock) begin
        if (reset) begin
            r_post_rst <= 1'b1;
        end else begin
            r_post_rst <= 1'b0;
        end
    end

    // FSM state register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic together with grant, issue and response strobes
    always_comb begin
        w_state_nxt = r_state;
        w_grant_ifu = 1'b0;
        w_grant_lsu = 1'b0;
        w_issue     = 1'b0;
        w_rsp_fire  = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_quiet && (w_sel_grant != 2'b00)) begin
                    w_grant_ifu = w_sel_grant[c_GNT_IFU];
                    w_grant_lsu = w_sel_grant[c_GNT_LSU];
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                w_issue = 1'b1;
                if (mem_req_ready) begin
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (mem_rsp_valid) begin
                    w_rsp_fire  = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Capture the granted request; fields stay frozen until the next grant
    always_ff @(posedge clock) begin
        if (reset) begin
            r_owner <= OWNER_IFU;
            r_addr  <= '0;
            r_wen   <= 1'b0;
            r_wdata <= '0;
            r_wmask <= '0;
        end else if (w_grant_lsu) begin
            r_owner <= OWNER_LSU;
            r_addr  <= lsu_addr;
            r_wen   <= lsu_wen;
            r_wdata <= lsu_wdata;
            r_wmask <= lsu_wmask;
        end else if (w_grant_ifu) begin
            r_owner <= OWNER_IFU;
            r_addr  <= ifu_addr;
            r_wen   <= 1'b0;
            r_wdata <= '0;
            r_wmask <= '0;
        end
    end

    // Request handshakes: ready is only ever given to the granted side
    assign ifu_req_ready = w_grant_ifu;
    assign lsu_req_ready = w_grant_lsu;

    // Memory request side driven from the latched fields
    assign mem_req_valid = w_issue & ~w_quiet;
    assign mem_addr      = w_quiet ? '0 : r_addr;
    assign mem_wen       = w_quiet ? 1'b0 : r_wen;
    assign mem_wdata     = w_quiet ? '0 : r_wdata;
    assign mem_wmask     = w_quiet ? '0 : r_wmask;

    // Response routed only to the owner; non-owner sees zeros
    assign w_ifu_fire    = w_rsp_fire & ~w_quiet & (r_owner == OWNER_IFU);
    assign w_lsu_fire    = w_rsp_fire & ~w_quiet & (r_owner == OWNER_LSU);
    assign ifu_rsp_valid = w_ifu_fire;
    assign lsu_rsp_valid = w_lsu_fire;
    assign ifu_rsp_data  = w_ifu_fire ? mem_rsp_data : '0;
    assign lsu_rsp_data  = w_lsu_fire ? mem_rsp_data : '0;

endmodule
`default_nettype wire

// File: doc/ysyx_25020047_mem_arb.md
YSYX_25020047_MEM_ARB -- requirements
Module: ysyx_25020047_mem_arb

Interface
REQ-001 SHALL have parameter AW, default 32: address width of all request ports.
REQ-002 SHALL have parameter DW, default 32: data width of all data ports.
REQ-003 SHALL have port clock  in  1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  in  1: synchronous reset, active-high.
REQ-005 SHALL have the IFU request ports:
- ifu_req_valid  in  1: fetch request.
- ifu_req_ready  out  1: fetch request accepted.
- ifu_addr  in  AW: fetch address.
REQ-006 SHALL have the IFU response ports:
- ifu_rsp_valid  out  1: fetch data valid.
- ifu_rsp_data  out  DW: fetch data.
REQ-007 SHALL have the LSU request ports:
- lsu_req_valid  in  1: load/store request.
- lsu_req_ready  out  1: load/store request accepted.
- lsu_addr  in  AW: load/store address.
- lsu_wen  in  1: 1 = store, 0 = load.
- lsu_wdata  in  DW: store data, already lane-aligned.
- lsu_wmask  in  DW/8: byte strobes.
REQ-008 SHALL have the LSU response ports:
- lsu_rsp_valid  out  1: load data or store acknowledge.
- lsu_rsp_data  out  DW: load data.
REQ-009 SHALL have the memory request ports:
- mem_req_valid  out  1: memory request.
- mem_req_ready  in  1: memory accepted the request.
- mem_addr  out  AW: memory address.
- mem_wen  out  1: write enable.
- mem_wdata  out  DW: write data.
- mem_wmask  out  DW/8: byte strobes.
REQ-010 SHALL have the memory response ports:
- mem_rsp_valid  in  1: memory response.
- mem_rsp_data  in  DW: memory read data.

Function
REQ-011 SHALL implement FSM states IDLE, ISSUE and WAIT, plus a 1-bit owner register (0 = IFU, 1 = LSU).
REQ-012 IDLE SHALL behave as follows:
- If either request valid is high, the arbiter grants one requester, asserts that requester's req_ready combinationally in the same cycle, latches its addr/wen/wdata/wmask and owner, and goes to ISSUE.
- IFU requests latch wen=0 and wmask=0.
REQ-013 req_ready SHALL be high only in IDLE and only for the granted requester; it SHALL never be high for both requesters in the same cycle.
REQ-014 ISSUE SHALL assert mem_req_valid with the latched fields held stable, and SHALL go to WAIT on the cycle mem_req_valid && mem_req_ready.
REQ-015 WAIT SHALL hold mem_req_valid=0; on mem_rsp_valid it SHALL go to IDLE.
REQ-016 During the WAIT cycle with mem_rsp_valid high, the owner's rsp_valid SHALL be 1 for exactly that cycle, and its rsp_data SHALL equal mem_rsp_data (combinational pass-through).
REQ-017 A store SHALL also receive lsu_rsp_valid as its write acknowledge.
REQ-018 The non-owner's rsp_valid SHALL be 0, and its rsp_data SHALL be 0.
REQ-019 mem_rsp_valid arriving in IDLE or ISSUE SHALL be ignored and SHALL produce no rsp_valid.
REQ-020 Minimum request-to-response latency SHALL be 2 cycles:
- accept at cycle T;
- mem_req_valid at T+1, accepted at T+1;
- response at T+2 at earliest;
- next grant possible at T+3.
REQ-021 Only one transaction SHALL be outstanding at a time; no request pipelining.
REQ-022 With both request valids high in IDLE, the tie SHALL be resolved per REQ-027/REQ-028.
REQ-023 Requesters SHALL be allowed to drop valid before ready; nothing is latched in that case.

Reset
REQ-024 On reset=1 at a clock edge, the FSM SHALL enter IDLE, owner=0 and the latched fields=0, regardless of any in-flight transaction.
REQ-025 A response to a transaction dropped by reset SHALL be discarded (REQ-019).
REQ-026 While in reset and in the cycle after it, all outputs SHALL be 0: mem_req_valid, both req_ready, both rsp_valid, and all data outputs.

Configuration
REQ-027 With macro YSYX_25020047_ARB_RR_EN defined:
- Ties SHALL be resolved round-robin using a 1-bit last_grant register (reset 0 = IFU).
- The requester not granted last SHALL win, and last_grant SHALL update on every grant.
REQ-028 Without YSYX_25020047_ARB_RR_EN, ties SHALL be resolved by fixed priority, LSU over IFU, and no last_grant register SHALL exist.

Structure
REQ-029 The shared package SHALL hold the FSM state encoding (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2), the owner encoding, and the AW/DW defaults.
REQ-030 The grant logic SHALL be one sub-module, ysyx_25020047_arb_sel:
- inputs: two valids and last_grant;
- outputs: one-hot grant;
- contents: fixed-priority or round-robin selection per the macro.

Verification
REQ-031 Single IFU fetch: ifu_addr=0x80000000, mem_req_ready=1, response one cycle later with data 0x00000413 -> ifu_rsp_valid pulses at T+2 with ifu_rsp_data=0x00000413; lsu_rsp_valid stays 0.
REQ-032 LSU store: lsu_addr=0x80001002, wdata=0x00AB0000, wmask=4'b0100 -> mem_wen=1 with the same addr/wdata/mask held through a 3-cycle mem_req_ready stall; lsu_rsp_valid pulses once.
REQ-033 Simultaneous requests, both valids held high for 4 grants:
- fixed priority: LSU,LSU,LSU,LSU;
- with YSYX_25020047_ARB_RR_EN: LSU,IFU,LSU,IFU.
REQ-034 Reset mid-transaction: reset in WAIT, then mem_rsp_valid next cycle -> no rsp_valid on either port; FSM in IDLE.
REQ-035 Spurious response: mem_rsp_valid=1 in IDLE with no requests -> both rsp_valid stay 0; the next grant proceeds normally.
